branch_fetch_ctrl: RTL and testbench
====================================

Name: branch_fetch_ctrl

Overview:
- Parametrised next-generation branch/fetch sequencer for the N-wide front end.
- Each cycle it receives LANES instruction words from the aligned fetch group, masks lanes that lie before a redirect entry point or after a taken branch, and predicts conditional branches with a 2-bit counter table.
- Steers pc_out, squashes overshoot groups, accepts late branch resolution from the execute stage, and runs the HALT state machine that records the halt address.

Parameters:
- PC_W, 9: PC width in instruction words.
- LANES, 2: instructions per fetch group; power of 2, range 1..8. OFF_W = log2(LANES).
- BHT_DEPTH, 16: number of 2-bit counters; power of 2. BHT_W = log2(BHT_DEPTH).
- FETCH_LAT, 1: cycles from pc_out to ir_in; also the squash length after any redirect, range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fetch_en  in  1  pipeline advance; 0 = stall.
- ir_in  in  16*LANES  current fetch group; lane k is at ir_in[16k+15:16k].
- pc_out  out  PC_W  next group fetch address; low OFF_W bits are always 0.
- lane_valid_out  out  LANES  lane k of ir_in may issue.
- lane_pred_out  out  LANES  lane k is a branch predicted taken.
- resolve_valid  in  1  a conditional branch resolved this cycle.
- resolve_pc  in  PC_W  PC of the resolved branch.
- resolve_taken  in  1  actual outcome.
- resolve_mispredict  in  1  redirect required.
- resolve_target  in  PC_W  correct-path PC.
- halted  out  1  HALT state reached.
- halt_addr  out  8  low 8 bits of (HALT PC + 1).

Behaviour:
- Reset (rst low, asynchronous):
  - pc_out = 0, group_pc = 0, entry_off = 0, squash_cnt = 0.
  - State RUN; halted = 0; halt_addr = 0.
  - All BHT counters = 2'b01 (weakly not-taken).
  - lane_valid_out = 0 and lane_pred_out = 0 while in reset.
- group_pc register: loaded with pc_out on each fetch_en cycle, delayed by FETCH_LAT stages, so it is the PC of ir_in. lane_pc(k) = group_pc + k.
- Decode: opcode = IR[15:13], cond = IR[10:8], imm = IR[7:0] sign-extended.
  - Branch: opcode 001 with cond 000..100.
  - target = lane_pc + 1 + imm, modulo 2^PC_W.
  - HALT: opcode 111.
- Base lane mask (combinational): lane k eligible iff state RUN, squash_cnt == 0, and k >= entry_off.
- Prediction:
  - cond 000 is always taken.
  - cond 001..100 is taken iff BHT[lane_pc[BHT_W-1:0]] >= 2.
  - The first eligible lane that is predicted taken or HALT is the terminator t. Lanes > t are invalid; lane t itself is valid.
- Next PC on fetch_en = 1, no mispredict:
  - Taken terminator: pc_out <= {target[PC_W-1:OFF_W], 0}; entry_off <= target[OFF_W-1:0]; squash_cnt <= FETCH_LAT.
  - Otherwise: pc_out <= pc_out + LANES, wrapping at 2^PC_W; entry_off <= 0.
  - squash_cnt decrements once per fetch_en cycle while nonzero.
- HALT terminator with fetch_en = 1:
  - State moves to HALTED; halted = 1 from the next cycle.
  - halt_addr <= (lane_pc + 1)[7:0].
  - pc_out freezes.
  - Exit only via reset; all inputs are ignored afterwards except that the BHT still updates.
- Resolution (independent of fetch_en):
  - resolve_valid updates BHT[resolve_pc[BHT_W-1:0]]: increment if taken, else decrement, saturating at 0 and 3.
  - resolve_mispredict redirects next cycle: pc_out <= aligned resolve_target; entry_off <= resolve_target[OFF_W-1:0]; squash_cnt <= FETCH_LAT.
  - Mispredict has priority over a same-cycle fetch-stage branch or HALT; that HALT is wrong-path and is not taken.
  - Mispredict in HALTED is ignored.
- Stall (fetch_en = 0): pc_out, group_pc, entry_off and squash_cnt hold; outputs still reflect the current ir_in. A resolve redirect still applies.
- Same-index BHT update and read in one cycle: the read returns the old value.

Test Plan:
- Reset release, LANES=2, NOPs on ir_in -> pc_out sequence 0, 2, 4, …; lane_valid_out = 2'b11 once the first group arrives.
- Unconditional B in lane 0 of group 0x04, imm = +0x0C -> target 0x11:
  - lane_valid_out = 2'b01 for group 0x04;
  - pc_out = 0x10;
  - one squashed group (lane_valid_out = 00);
  - then group 0x10 with lane_valid_out = 2'b10.
- BEQ at PC 0x06, counter reset = 01 -> not predicted.
  - Resolve taken twice: counter reaches 11.
  - Next fetch of 0x06: lane_pred_out[0] = 1 and redirect.
  - Four not-taken resolves: counter saturates at 00.
- resolve_mispredict with target 0x23 in the same cycle as a predicted branch in the fetch stage -> pc_out = 0x22, entry_off = 1; the fetch-stage branch is ignored.
- HALT in lane 1 at PC 0x31 -> halted = 1, halt_addr = 0x32, pc_out frozen. fetch_en toggling and a mispredict afterwards cause no change.
- rst asserted mid-squash with pc_out = 0x40 -> immediate async return to all reset values; the BHT reads back 01.

Source files
------------

// File: rtl/branch_fetch_ctrl.sv
// Branch/fetch sequencer for an N-wide front end: lane masking, 2-bit BHT
// prediction, redirect/squash steering, late resolution and HALT capture.
module branch_fetch_ctrl #(
  parameter int PC_W      = 9,
  parameter int LANES     = 2,
  parameter int BHT_DEPTH = 16,
  parameter int FETCH_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic [16*LANES-1:0]   ir_in,
  output logic [PC_W-1:0]       pc_out,
  output logic [LANES-1:0]      lane_valid_out,
  output logic [LANES-1:0]      lane_pred_out,
  input  logic                  resolve_valid,
  input  logic [PC_W-1:0]       resolve_pc,
  input  logic                  resolve_taken,
  input  logic                  resolve_mispredict,
  input  logic [PC_W-1:0]       resolve_target,
  output logic                  halted,
  output logic [7:0]            halt_addr
);

  localparam int OFF_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BHT_W = $clog2(BHT_DEPTH);
  localparam logic [PC_W-1:0] OFF_MASK = PC_W'(LANES - 1);

  typedef enum logic {ST_RUN, ST_HALTED} state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  gp_q [FETCH_LAT];
  logic [OFF_W-1:0] entry_q, entry_d;
  logic [2:0]       squash_q, squash_d;
  logic [7:0]       halt_addr_q, halt_addr_d;
  logic [1:0]       bht_q [BHT_DEPTH];

  logic [PC_W-1:0]  group_pc;
  logic             gp_adv;

  // Per-lane decode temporaries and terminator summary.
  logic [PC_W-1:0]  lpc;
  logic [2:0]       opcode, cond;
  logic             is_br, is_halt, br_taken, eligible;
  logic             found, term_halt;
  logic [PC_W-1:0]  term_target, term_pc;
  logic [LANES-1:0] valid, pred;

  logic [BHT_W-1:0] res_idx;
  logic [1:0]       res_cur, res_nxt;
  logic             unused_fields;

  assign group_pc = gp_q[FETCH_LAT-1];

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    found       = 1'b0;
    term_halt   = 1'b0;
    term_target = '0;
    term_pc     = '0;
    valid       = '0;
    pred        = '0;
    lpc         = '0;
    opcode      = '0;
    cond        = '0;
    is_br       = 1'b0;
    is_halt     = 1'b0;
    br_taken    = 1'b0;
    eligible    = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      lpc      = group_pc + PC_W'(k);
      opcode   = ir_in[16*k+13 +: 3];
      cond     = ir_in[16*k+8 +: 3];
      is_br    = (opcode == 3'b001) && (cond <= 3'd4);
      is_halt  = (opcode == 3'b111);
      br_taken = is_br && ((cond == 3'd0) || bht_q[lpc[BHT_W-1:0]][1]);
      eligible = (state_q == ST_RUN) && (squash_q == 3'd0) && (k >= int'(entry_q));
      if (eligible && !found) begin
        valid[k] = 1'b1;
        pred[k]  = br_taken;
        if (br_taken || is_halt) begin
          found       = 1'b1;
          term_halt   = is_halt;
          term_pc     = lpc;
          term_target = lpc + PC_W'(1) + PC_W'($signed(ir_in[16*k +: 8]));
        end
      end
    end
  end

  always_comb begin
    unused_fields = ^resolve_pc;
    for (int k = 0; k < LANES; k++) unused_fields = unused_fields ^ (^ir_in[16*k+11 +: 2]);
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    entry_d     = entry_q;
    squash_d    = squash_q;
    halt_addr_d = halt_addr_q;
    gp_adv      = 1'b0;
    if (state_q == ST_RUN) begin
      gp_adv = fetch_en;
      // A late mispredict outranks anything the fetch stage wants this cycle.
      if (resolve_mispredict) begin
        pc_d     = resolve_target & ~OFF_MASK;
        entry_d  = OFF_W'(resolve_target & OFF_MASK);
        squash_d = 3'(FETCH_LAT);
      end else if (fetch_en) begin
        if (found && term_halt) begin
          state_d     = ST_HALTED;
          halt_addr_d = 8'(32'(term_pc) + 32'd1);
          gp_adv      = 1'b0;
        end else if (found) begin
          pc_d     = term_target & ~OFF_MASK;
          entry_d  = OFF_W'(term_target & OFF_MASK);
          squash_d = 3'(FETCH_LAT);
        end else begin
          pc_d = pc_q + PC_W'(LANES);
          if (squash_q != 3'd0) squash_d = squash_q - 3'd1;
          else                  entry_d  = '0;
        end
      end
    end
  end

  always_comb begin
    res_idx = resolve_pc[BHT_W-1:0];
    res_cur = bht_q[res_idx];
    res_nxt = res_cur;
    if (resolve_taken && res_cur != 2'b11)       res_nxt = res_cur + 2'b01;
    else if (!resolve_taken && res_cur != 2'b00) res_nxt = res_cur - 2'b01;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      pc_q        <= '0;
      entry_q     <= '0;
      squash_q    <= '0;
      halt_addr_q <= '0;
      for (int i = 0; i < FETCH_LAT; i++) gp_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      entry_q     <= entry_d;
      squash_q    <= squash_d;
      halt_addr_q <= halt_addr_d;
      if (gp_adv) begin
        gp_q[0] <= pc_q;
        for (int i = 1; i < FETCH_LAT; i++) gp_q[i] <= gp_q[i-1];
      end
    end
  end

  // NOTE: the BHT is a small flop array that must come up weakly not-taken,
  // so it is reset like any other register rather than left uninitialised.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (resolve_valid) begin
      bht_q[res_idx] <= res_nxt;
    end
  end

  assign pc_out         = pc_q;
  assign lane_valid_out = rst ? valid : '0;
  assign lane_pred_out  = rst ? pred  : '0;
  assign halted         = (state_q == ST_HALTED);
  assign halt_addr      = halt_addr_q;

endmodule

// File: tb/tb_branch_fetch_ctrl.sv
// Directed bench for branch_fetch_ctrl (LANES=2, PC_W=9, FETCH_LAT=1) with a
// one-cycle instruction memory feeding ir_in from pc_out.
module tb_branch_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] ir_in;
  logic [8:0]  pc_out;
  logic [1:0]  lane_valid_out;
  logic [1:0]  lane_pred_out;
  logic        resolve_valid;
  logic [8:0]  resolve_pc;
  logic        resolve_taken;
  logic        resolve_mispredict;
  logic [8:0]  resolve_target;
  logic        halted;
  logic [7:0]  halt_addr;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] imem [512];
  logic [8:0]  fetch_pc;

  branch_fetch_ctrl #(.PC_W(9), .LANES(2), .BHT_DEPTH(16), .FETCH_LAT(1)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_en           (fetch_en),
    .ir_in              (ir_in),
    .pc_out             (pc_out),
    .lane_valid_out     (lane_valid_out),
    .lane_pred_out      (lane_pred_out),
    .resolve_valid      (resolve_valid),
    .resolve_pc         (resolve_pc),
    .resolve_taken      (resolve_taken),
    .resolve_mispredict (resolve_mispredict),
    .resolve_target     (resolve_target),
    .halted             (halted),
    .halt_addr          (halt_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst)          fetch_pc <= '0;
    else if (fetch_en) fetch_pc <= pc_out;
  end
  assign ir_in = {imem[9'(fetch_pc + 9'd1)], imem[fetch_pc]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mispredict(input logic [8:0] tgt);
    resolve_mispredict = 1'b1;
    resolve_target     = tgt;
    tick();
    resolve_mispredict = 1'b0;
  endtask

  task automatic resolve(input logic [8:0] pc, input logic taken, input int n);
    resolve_valid = 1'b1;
    resolve_pc    = pc;
    resolve_taken = taken;
    repeat (n) tick();
    resolve_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) imem[i] = 16'h0000;
    imem[9'h004] = 16'h200C;  // B always, imm +0x0C -> 0x11
    imem[9'h006] = 16'h2108;  // BEQ, imm +0x08 -> 0x0F
    imem[9'h031] = 16'hE000;  // HALT

    rst = 1'b0; fetch_en = 1'b0;
    resolve_valid = 1'b0; resolve_pc = '0; resolve_taken = 1'b0;
    resolve_mispredict = 1'b0; resolve_target = '0;

    #12;
    check("rst_pc", 32'(pc_out), 32'h0);
    check("rst_valid", 32'(lane_valid_out), 32'h0);
    check("rst_pred", 32'(lane_pred_out), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_haddr", 32'(halt_addr), 32'h0);

    #10; rst = 1'b1; fetch_en = 1'b1;
    #1;
    check("first_valid", 32'(lane_valid_out), 32'h3);
    tick(); check("seq_pc2", 32'(pc_out), 32'h2);
    tick(); check("seq_pc4", 32'(pc_out), 32'h4);
    fetch_en = 1'b0;
    tick(); check("stall_pc", 32'(pc_out), 32'h4);
    fetch_en = 1'b1;
    tick();
    check("b_pc6", 32'(pc_out), 32'h6);
    check("b_valid", 32'(lane_valid_out), 32'h1);
    check("b_pred", 32'(lane_pred_out), 32'h1);
    tick();
    check("b_redirect_pc", 32'(pc_out), 32'h10);
    check("b_squash", 32'(lane_valid_out), 32'h0);
    tick();
    check("b_entry_valid", 32'(lane_valid_out), 32'h2);
    check("b_pc_next", 32'(pc_out), 32'h12);

    // BEQ at 0x06 with its counter at reset value 01.
    mispredict(9'h006); tick();
    check("beq_np_valid", 32'(lane_valid_out), 32'h3);
    check("beq_np_pred", 32'(lane_pred_out), 32'h0);

    resolve(9'h006, 1'b1, 3);  // 01 -> 10 -> 11 -> 11
    mispredict(9'h006); tick();
    check("beq_p_pred", 32'(lane_pred_out), 32'h1);
    check("beq_p_valid", 32'(lane_valid_out), 32'h1);
    tick(); check("beq_p_pc", 32'(pc_out), 32'h0E);
    tick(); check("beq_p_entry", 32'(lane_valid_out), 32'h2);

    resolve(9'h006, 1'b0, 4);  // 11 -> 10 -> 01 -> 00 -> 00
    resolve(9'h006, 1'b1, 1);  // 00 -> 01
    mispredict(9'h006); tick();
    check("bht_sat_low", 32'(lane_pred_out), 32'h0);
    resolve(9'h006, 1'b1, 1);  // 01 -> 10
    mispredict(9'h006); tick();
    check("bht_inc", 32'(lane_pred_out), 32'h1);

    // Mispredict in the same cycle as a predicted branch in the fetch stage.
    mispredict(9'h004); tick();
    check("mp_fetch_pred", 32'(lane_pred_out), 32'h1);
    mispredict(9'h023);
    check("mp_pc", 32'(pc_out), 32'h22);
    tick();
    check("mp_entry", 32'(lane_valid_out), 32'h2);

    // HALT in lane 1 of group 0x30.
    mispredict(9'h030); tick();
    check("halt_lanes", 32'(lane_valid_out), 32'h3);
    check("halt_pre", 32'(halted), 32'h0);
    tick();
    check("halted", 32'(halted), 32'h1);
    check("halt_addr", 32'(halt_addr), 32'h32);
    check("halt_pc", 32'(pc_out), 32'h32);
    check("halt_valid", 32'(lane_valid_out), 32'h0);
    fetch_en = 1'b0; tick(); fetch_en = 1'b1; tick();
    mispredict(9'h050); tick();
    check("halt_frozen_pc", 32'(pc_out), 32'h32);
    check("halt_stays", 32'(halted), 32'h1);
    check("halt_addr_keep", 32'(halt_addr), 32'h32);

    // Leave HALTED through reset.
    rst = 1'b0;
    #1; check("rst2_halted", 32'(halted), 32'h0);
    #3; rst = 1'b1;
    tick();

    // Async reset in the middle of a squash, after training the counter.
    resolve(9'h006, 1'b1, 2);  // 01 -> 11
    mispredict(9'h040);
    check("sq_pc", 32'(pc_out), 32'h40);
    check("sq_valid", 32'(lane_valid_out), 32'h0);
    #2; rst = 1'b0;
    #1;
    check("async_pc", 32'(pc_out), 32'h0);
    check("async_haddr", 32'(halt_addr), 32'h0);
    #1; rst = 1'b1;
    #1;
    check("post_rst_valid", 32'(lane_valid_out), 32'h3);
    mispredict(9'h006); tick();
    check("bht_reset", 32'(lane_pred_out), 32'h0);
    resolve(9'h006, 1'b1, 1);  // 01 -> 10
    mispredict(9'h006); tick();
    check("bht_reset_inc", 32'(lane_pred_out), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
